// File: rtl/dfe_round_pkg.sv
// Shared definitions for the DFE round-and-saturate stage: rounding mode
// encodings and the signed saturation bound helpers.
package dfe_round_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC = 2'd0,
        RND_HAFZ  = 2'd1,
        RND_CONV  = 2'd2,
        RND_HUP   = 2'd3
    } rnd_mode_e;

    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/data_round_sat_lane.sv
// One channel of the round-and-saturate stage: rounding-bias add (stage 1),
// arithmetic shift with saturation (stage 2) and the sticky saturation counter.
module data_round_sat_lane
    import dfe_round_pkg::*;
#(
    parameter int DIN_WIDTH  = 39,
    parameter int DOUT_WIDTH = 17,
    parameter int DROP_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    input  rnd_mode_e                    i_mode,
    input  logic [DROP_WIDTH-1:0]        i_drop,
    input  logic signed [DIN_WIDTH-1:0]  i_data,
    input  logic                         i_valid_s2,
    input  logic [DROP_WIDTH-1:0]        i_drop_s2,
    input  logic                         i_clr_cnt,
    output logic [DOUT_WIDTH-1:0]        o_data,
    output logic                         o_sat,
    output logic [CNT_WIDTH-1:0]         o_sat_cnt
);

    localparam int SW = DIN_WIDTH + 1;
    localparam logic signed [SW-1:0] R_MAX = SW'(sat_max(DOUT_WIDTH));
    localparam logic signed [SW-1:0] R_MIN = SW'(sat_min(DOUT_WIDTH));

    logic signed [SW-1:0]   sExt;
    logic signed [SW-1:0]   half;
    logic signed [SW-1:0]   bias;
    logic                   lsbKept;
    logic signed [SW-1:0]   sum_d, sum_q;
    logic signed [SW-1:0]   shifted;
    logic                   satHi, satLo;
    logic [DOUT_WIDTH-1:0]  data_d, data_q;
    logic                   sat_d, sat_q;
    logic [CNT_WIDTH-1:0]   cnt_d, cnt_q;

    // One extra bit of headroom so the rounding bias can never wrap the sum.
    always_comb begin
        sExt    = {i_data[DIN_WIDTH-1], i_data};
        half    = '0;
        bias    = '0;
        lsbKept = |((sExt >> i_drop) & SW'(1));
        if (i_drop != '0) begin
            half = SW'(1) << (i_drop - 1'b1);
            unique case (i_mode)
                RND_TRUNC: bias = '0;
                RND_HAFZ:  bias = i_data[DIN_WIDTH-1] ? half - SW'(1) : half;
                RND_CONV:  bias = half - SW'(1) + {{(SW-1){1'b0}}, lsbKept};
                RND_HUP:   bias = half;
                default:   bias = '0;
            endcase
        end
        sum_d = sExt + bias;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_q <= '0;
        end else if (i_valid) begin
            sum_q <= sum_d;
        end
    end

    always_comb begin
        shifted = sum_q >>> i_drop_s2;
        satHi   = shifted > R_MAX;
        satLo   = shifted < R_MIN;
        data_d  = data_q;
        sat_d   = 1'b0;
        if (i_valid_s2) begin
            sat_d = satHi | satLo;
            if (satHi) begin
                data_d = R_MAX[DOUT_WIDTH-1:0];
            end else if (satLo) begin
                data_d = R_MIN[DOUT_WIDTH-1:0];
            end else begin
                data_d = shifted[DOUT_WIDTH-1:0];
            end
        end
    end

    // Clear wins over a coincident event; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr_cnt) begin
            cnt_d = '0;
        end else if (sat_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= '0;
            sat_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            sat_q  <= sat_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_data    = data_q;
    assign o_sat     = sat_q;
    assign o_sat_cnt = cnt_q;

endmodule

// File: rtl/data_round_sat.sv
// Multi-channel round-and-saturate stage: owns the valid and drop pipeline
// and instantiates one lane per channel.
module data_round_sat
    import dfe_round_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DIN_WIDTH  = 39,
    parameter int DOUT_WIDTH = 17,
    parameter int DROP_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    input  logic [NCH*DIN_WIDTH-1:0]   i_data,
    input  logic [1:0]                 i_mode,
    input  logic [DROP_WIDTH-1:0]      i_drop,
    input  logic                       i_clr_cnt,
    output logic                       o_valid,
    output logic [NCH*DOUT_WIDTH-1:0]  o_data,
    output logic [NCH-1:0]             o_sat,
    output logic [NCH*CNT_WIDTH-1:0]   o_sat_cnt
);

    localparam logic [DROP_WIDTH-1:0] MAX_DROP = DROP_WIDTH'(DIN_WIDTH - DOUT_WIDTH);

    logic [DROP_WIDTH-1:0] dropEff;
    logic [DROP_WIDTH-1:0] drop_q;
    logic                  valid1_q, valid2_q;

    assign dropEff = (i_drop > MAX_DROP) ? MAX_DROP : i_drop;

    // The clamped drop follows its sample into stage 2 so changes land on sample boundaries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            valid1_q <= i_valid;
            valid2_q <= valid1_q;
            if (i_valid) begin
                drop_q <= dropEff;
            end
        end
    end

    assign o_valid = valid2_q;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_lane
        data_round_sat_lane #(
            .DIN_WIDTH  (DIN_WIDTH),
            .DOUT_WIDTH (DOUT_WIDTH),
            .DROP_WIDTH (DROP_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_lane (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_valid    (i_valid),
            .i_mode     (rnd_mode_e'(i_mode)),
            .i_drop     (dropEff),
            .i_data     (i_data[ch*DIN_WIDTH +: DIN_WIDTH]),
            .i_valid_s2 (valid1_q),
            .i_drop_s2  (drop_q),
            .i_clr_cnt  (i_clr_cnt),
            .o_data     (o_data[ch*DOUT_WIDTH +: DOUT_WIDTH]),
            .o_sat      (o_sat[ch]),
            .o_sat_cnt  (o_sat_cnt[ch*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_data_round_sat.sv
// Directed, self-checking bench for data_round_sat with 12-bit inputs,
// 8-bit outputs, two channels and 4-bit saturation counters.
module tb_data_round_sat;

    localparam int NCH   = 2;
    localparam int DIN   = 12;
    localparam int DOUT  = 8;
    localparam int DROPW = 6;
    localparam int CNTW  = 4;

    logic                 clk;
    logic                 rstN;
    logic                 validIn;
    logic [NCH*DIN-1:0]   dataIn;
    logic [1:0]           modeIn;
    logic [DROPW-1:0]     dropIn;
    logic                 clrCnt;
    logic                 oValid;
    logic [NCH*DOUT-1:0]  oData;
    logic [NCH-1:0]       oSat;
    logic [NCH*CNTW-1:0]  oSatCnt;

    int checks = 0;
    int errors = 0;

    data_round_sat #(
        .NCH        (NCH),
        .DIN_WIDTH  (DIN),
        .DOUT_WIDTH (DOUT),
        .DROP_WIDTH (DROPW),
        .CNT_WIDTH  (CNTW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rstN),
        .i_valid   (validIn),
        .i_data    (dataIn),
        .i_mode    (modeIn),
        .i_drop    (dropIn),
        .i_clr_cnt (clrCnt),
        .o_valid   (oValid),
        .o_data    (oData),
        .o_sat     (oSat),
        .o_sat_cnt (oSatCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] e8(input int v);
        logic [7:0] t;
        t = v[7:0];
        return {24'b0, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input int mode, input int drop,
                                 input int x0, input int x1, input logic clr);
        validIn = v;
        modeIn  = 2'(mode);
        dropIn  = DROPW'(drop);
        dataIn  = {DIN'(x1), DIN'(x0)};
        clrCnt  = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkLane(input string tag, input int ch, input int expData, input int expSat);
        checkOutput({tag, " data"}, {24'b0, oData[ch*DOUT +: DOUT]}, e8(expData));
        checkOutput({tag, " sat"}, {31'b0, oSat[ch]}, 32'(expSat));
    endtask

    task automatic checkCnt(input string tag, input int ch, input int expCnt);
        checkOutput(tag, {28'b0, oSatCnt[ch*CNTW +: CNTW]}, 32'(expCnt));
    endtask

    // One isolated sample: drive it, idle, then check two edges later.
    task automatic runOne(input string tag, input int mode, input int drop,
                          input int x0, input int x1,
                          input int e0, input int s0, input int e1, input int s1);
        applyStimulus(1'b1, mode, drop, x0, x1, 1'b0);
        tick();
        applyStimulus(1'b0, mode, drop, 0, 0, 1'b0);
        tick();
        checkOutput({tag, " valid"}, {31'b0, oValid}, 32'd1);
        checkLane({tag, " ch0"}, 0, e0, s0);
        checkLane({tag, " ch1"}, 1, e1, s1);
    endtask

    int xs[3]        = '{40, -40, 24};
    int exp0[3][4]   = '{'{2, 3, 2, 3}, '{-3, -3, -2, -2}, '{1, 2, 2, 2}};
    int exp1[3][4]   = '{'{-3, -3, -2, -2}, '{2, 3, 2, 3}, '{-2, -2, -2, -1}};
    int modeSeq[8]   = '{0, 1, 2, 3, 3, 0, 2, 1};

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        #12;
        checkOutput("reset valid", {31'b0, oValid}, 32'd0);
        checkOutput("reset data", {16'b0, oData}, 32'd0);
        checkOutput("reset sat", {30'b0, oSat}, 32'd0);
        checkOutput("reset cnt", {24'b0, oSatCnt}, 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        tick();

        $display("[TB] rounding modes at D=4");
        for (int i = 0; i < 3; i++) begin
            for (int m = 0; m < 4; m++) begin
                runOne($sformatf("t1 x=%0d m=%0d", xs[i], m), m, 4, xs[i], -xs[i],
                       exp0[i][m], 0, exp1[i][m], 0);
            end
        end
        tick();
        checkOutput("t1 idle valid", {31'b0, oValid}, 32'd0);
        checkLane("t1 idle hold ch0", 0, 2, 0);
        checkLane("t1 idle hold ch1", 1, -1, 0);

        $display("[TB] saturation at D=0");
        runOne("t2 +300", 0, 0, 300, 5, 127, 1, 5, 0);
        runOne("t2 -300", 0, 0, -300, -5, -128, 1, -5, 0);
        checkCnt("t2 cnt0", 0, 2);
        checkCnt("t2 cnt1", 1, 0);
        runOne("t2 127", 0, 0, 127, 0, 127, 0, 0, 0);
        checkCnt("t2 cnt0 after", 0, 2);

        $display("[TB] per-sample mode changes");
        for (int k = 0; k < 10; k++) begin
            if (k < 8) applyStimulus(1'b1, modeSeq[k], 4, 40, 24, 1'b0);
            else       applyStimulus(1'b0, 0, 4, 0, 0, 1'b0);
            tick();
            if (k == 0 || k == 9) begin
                checkOutput($sformatf("t3 k=%0d no valid", k), {31'b0, oValid}, 32'd0);
            end else begin
                checkOutput($sformatf("t3 k=%0d valid", k), {31'b0, oValid}, 32'd1);
                checkLane($sformatf("t3 k=%0d ch0", k), 0, exp0[0][modeSeq[k-1]], 0);
                checkLane($sformatf("t3 k=%0d ch1", k), 1, exp0[2][modeSeq[k-1]], 0);
            end
        end

        $display("[TB] counter saturation and clear");
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
        tick();
        checkCnt("t4 clr cnt0", 0, 0);
        for (int i = 0; i < 19; i++) begin
            applyStimulus(1'b1, 0, 0, 2047, 1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        tick();
        tick();
        checkCnt("t4 sticky cnt0", 0, 15);
        checkCnt("t4 cnt1", 1, 0);
        applyStimulus(1'b1, 0, 0, 2047, 1, 1'b0);
        tick();
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1);
        tick();
        checkLane("t4 clr+sat ch0", 0, 127, 1);
        checkCnt("t4 clr+sat cnt0", 0, 0);
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        tick();

        $display("[TB] reset mid-burst");
        applyStimulus(1'b1, 0, 0, 2047, -2048, 1'b0);
        tick();
        applyStimulus(1'b1, 1, 4, 40, 24, 1'b0);
        tick();
        checkOutput("t5 pre valid", {31'b0, oValid}, 32'd1);
        checkLane("t5 pre ch0", 0, 127, 1);
        checkLane("t5 pre ch1", 1, -128, 1);
        checkCnt("t5 pre cnt1", 1, 1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("t5 rst valid", {31'b0, oValid}, 32'd0);
        checkOutput("t5 rst data", {16'b0, oData}, 32'd0);
        checkOutput("t5 rst sat", {30'b0, oSat}, 32'd0);
        checkOutput("t5 rst cnt", {24'b0, oSatCnt}, 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        tick();
        checkOutput("t5 post1 valid", {31'b0, oValid}, 32'd0);
        tick();
        checkOutput("t5 post2 valid", {31'b0, oValid}, 32'd0);
        applyStimulus(1'b1, 1, 4, -40, 40, 1'b0);
        tick();
        checkOutput("t5 lat1 valid", {31'b0, oValid}, 32'd0);
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
        tick();
        checkOutput("t5 lat2 valid", {31'b0, oValid}, 32'd1);
        checkLane("t5 new ch0", 0, -3, 0);
        checkLane("t5 new ch1", 1, 3, 0);

        $display("[TB] drop clamp and channel independence");
        runOne("t6 m3 drop31", 3, 31, 2047, 40, 127, 1, 3, 0);
        checkCnt("t6 cnt0", 0, 1);
        checkCnt("t6 cnt1", 1, 0);
        runOne("t6 m0 drop31", 0, 31, -40, 24, -3, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
